picorv32_pcpi_fpaddsub: RTL and testbench
=========================================

Name: picorv32_pcpi_fpaddsub

Overview:
Parametrised single-precision IEEE-754 add/subtract co-processor on the PicoRV32 PCPI bus; successor to the add-only PCPI FP adder. Decodes two custom R-type instructions (FADD, FSUB) with a per-instruction rounding mode taken from funct3. Multi-cycle iterative datapath. Clean one-cycle ready/wr pulse. Optional sticky exception flags.

Parameters:
OPCODE, 7'b0001011, major opcode matched on pcpi_insn[6:0]
FUNCT7_ADD, 7'b0000000, funct7 selecting rs1 + rs2
FUNCT7_SUB, 7'b0000100, funct7 selecting rs1 - rs2
DEFAULT_RM, 3'b000, rounding mode used when funct3 = 3'b111 (dynamic) or funct3 is reserved (101/110)

Ports:
clk  in  1  clock
resetn  in  1  reset; synchronous, active-low
pcpi_valid  in  1  instruction offered by CPU
pcpi_insn  in  32  instruction word
pcpi_rs1  in  32  operand a
pcpi_rs2  in  32  operand b
pcpi_wr  out  1  result write strobe
pcpi_rd  out  32  result
pcpi_wait  out  1  busy; suppresses CPU illegal-insn timeout
pcpi_ready  out  1  completion strobe
fflags  out  5  {NV,DZ,OF,UF,NX} sticky (FPADDSUB_FLAGS_EN only)
fflags_clr  in  1  clear fflags (FPADDSUB_FLAGS_EN only)

Behaviour:
- Reset (resetn=0 at clk edge): state IDLE; pcpi_wr, pcpi_wait, pcpi_ready = 0; pcpi_rd = 0; fflags = 0. Reset mid-operation aborts immediately, no strobe issued.
- Match: pcpi_valid && insn[6:0]==OPCODE && insn[31:25] in {FUNCT7_ADD, FUNCT7_SUB}. Other insns ignored (all outputs stay 0).
- States: IDLE -> UNPACK -> SPECIAL -> ALIGN -> ADD -> NORM -> ROUND -> PACK -> DONE -> COOL -> IDLE.
- IDLE: on match latch rs1, rs2, op, rm; pcpi_wait=1 from next cycle until the DONE cycle (exclusive).
- UNPACK: split sign/exp/mantissa; 3 extra GRS bits; SUB inverts b sign.
- SPECIAL: NaN in or inf + (-inf) -> canonical 0x7FC00000, NV set for any sNaN or invalid inf sum; inf -> signed inf; exact zeros handled per zero-sign rule; otherwise to ALIGN with hidden bit set (denormal exp forced to -126).
- ALIGN: one shift per cycle of smaller operand, LSB ORed into sticky; if exponent difference > 26, whole mantissa collapses to sticky in one cycle. ALIGN <= 27 cycles; total latency issue->ready <= 36 cycles.
- ADD: 28-bit magnitude add/sub, larger magnitude sign wins.
- NORM: carry-out right-shift once; else left-shift one bit/cycle while MSB=0 and exp > -126; then right-shift while exp < -126 (subnormal), sticky accumulates.
- ROUND: rm 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM. Mantissa carry-out increments exponent.
- PACK: exp > 127 -> RNE/RMM give inf; RTZ, and RDN on +/RUP on -, give 0x7F7FFFFF with sign; OF+NX set. Subnormal/zero result -> exp field 0; UF when tiny and inexact.
- Zero-sign rule: exact zero from opposite-signed operands is +0, except RDN gives -0; (-0)+(-0) = -0.
- DONE: pcpi_rd = result, pcpi_wr=1, pcpi_ready=1 for exactly one cycle, pcpi_wait=0.
- COOL: one cycle ignoring pcpi_valid so the completing insn is not re-accepted; pcpi_rd holds value.

Optional Feature:
FPADDSUB_FLAGS_EN: defined -> fflags port present; flags of each completed op ORed in at DONE; fflags_clr=1 zeroes flags (clear takes priority over same-cycle set); DZ always 0. Undefined -> fflags/fflags_clr ports absent, no flag logic; result datapath identical.

Test Plan:
FADD RNE 0x3F800000 + 0x40000000 -> single ready/wr pulse, rd=0x40400000, wait high throughout, latency <= 36.
FSUB 0x3F800000 - 0x3F800000 rm=RNE -> 0x00000000; same with rm=RDN -> 0x80000000.
0x3F800000 + 0x33800000: RNE -> 0x3F800000, RUP -> 0x3F800001, NX set (flags build).
0x7F7FFFFF + 0x7F7FFFFF: RNE -> 0x7F800000; RTZ -> 0x7F7FFFFF; OF+NX set.
0x7F800000 + 0xFF800000 -> 0x7FC00000, NV set; fflags_clr pulse -> fflags=0.
resetn low mid-ALIGN -> no ready/wr, all outputs 0; next FADD 0x00000001 + 0x00000001 -> 0x00000002.

Source files
------------

// File: rtl/picorv32_pcpi_fpaddsub.sv
// Iterative IEEE-754 single-precision FADD/FSUB co-processor on the PicoRV32 PCPI bus.
// Define FPADDSUB_FLAGS_EN to add the sticky fflags output and fflags_clr input.
module picorv32_pcpi_fpaddsub #(
  parameter logic [6:0] OPCODE     = 7'b0001011,
  parameter logic [6:0] FUNCT7_ADD = 7'b0000000,
  parameter logic [6:0] FUNCT7_SUB = 7'b0000100,
  parameter logic [2:0] DEFAULT_RM = 3'b000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
`ifdef FPADDSUB_FLAGS_EN
  ,
  output logic [4:0]  fflags,
  input  logic        fflags_clr
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK, S_DONE, S_COOL
  } state_t;

  state_t state_reg, state_next;

  logic [31:0]       a_reg, b_reg, result_reg;
  logic              sub_reg, sign_a_reg, sign_b_reg, sign_r_reg;
  logic [2:0]        rm_reg;
  logic signed [9:0] exp_a_reg, exp_b_reg, exp_r_reg;
  logic [26:0]       man_a_reg, man_b_reg;
  logic [27:0]       sum_reg;
  logic [23:0]       mant_reg;

  logic        match, unused_insn;
  logic [2:0]  rm_dec;
  assign match = pcpi_valid && (pcpi_insn[6:0] == OPCODE) &&
                 ((pcpi_insn[31:25] == FUNCT7_ADD) || (pcpi_insn[31:25] == FUNCT7_SUB));
  assign rm_dec = (pcpi_insn[14:12] > 3'b100) ? DEFAULT_RM : pcpi_insn[14:12];
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // Operand classification, read straight from the latched words.
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inf_invalid, special_hit, zero_sign;
  assign a_nan  = (&a_reg[30:23]) && (|a_reg[22:0]);
  assign b_nan  = (&b_reg[30:23]) && (|b_reg[22:0]);
  assign a_inf  = (&a_reg[30:23]) && !(|a_reg[22:0]);
  assign b_inf  = (&b_reg[30:23]) && !(|b_reg[22:0]);
  assign a_zero = !(|a_reg[30:0]);
  assign b_zero = !(|b_reg[30:0]);
  assign inf_invalid = a_inf && b_inf && (sign_a_reg != sign_b_reg);
  assign special_hit = a_nan || b_nan || a_inf || b_inf || (a_zero && b_zero);
  // Exact zero: same-signed operands keep their sign, otherwise -0 only under RDN.
  assign zero_sign = (sign_a_reg == sign_b_reg) ? sign_a_reg : (rm_reg == 3'b010);

  logic signed [9:0] exp_diff;
  assign exp_diff = exp_a_reg - exp_b_reg;

  logic        eff_sub, a_ge;
  logic [27:0] sum_comb;
  assign eff_sub  = sign_a_reg ^ sign_b_reg;
  assign a_ge     = man_a_reg >= man_b_reg;
  assign sum_comb = !eff_sub ? ({1'b0, man_a_reg} + {1'b0, man_b_reg}) :
                    a_ge     ? ({1'b0, man_a_reg} - {1'b0, man_b_reg}) :
                               ({1'b0, man_b_reg} - {1'b0, man_a_reg});

  logic norm_left, norm_right;
  assign norm_left  = !sum_reg[26] && (exp_r_reg > -10'sd126);
  assign norm_right = exp_r_reg < -10'sd126;

  logic        inexact, rnd_up;
  logic [24:0] mant_sum;
  assign inexact = |sum_reg[2:0];
  always_comb begin
    rnd_up = 1'b0;
    case (rm_reg)
      3'b000:  rnd_up = sum_reg[2] && (sum_reg[1] || sum_reg[0] || sum_reg[3]);
      3'b010:  rnd_up = inexact && sign_r_reg;
      3'b011:  rnd_up = inexact && !sign_r_reg;
      3'b100:  rnd_up = sum_reg[2];
      default: rnd_up = 1'b0;
    endcase
  end
  assign mant_sum = {1'b0, sum_reg[26:3]} + {24'd0, rnd_up};

  logic       overflow, ovf_inf;
  logic [7:0] exp_field;
  assign overflow  = mant_reg[23] && (exp_r_reg > 10'sd127);
  assign ovf_inf   = (rm_reg == 3'b000) || (rm_reg == 3'b100) ||
                     ((rm_reg == 3'b010) && sign_r_reg) || ((rm_reg == 3'b011) && !sign_r_reg);
  assign exp_field = 8'(exp_r_reg + 10'sd127);

  always_ff @(posedge clk) begin
    if (!resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pcpi_wr    = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wait  = 1'b0;
    pcpi_rd    = 32'd0;
    case (state_reg)
      S_IDLE:    if (match) state_next = S_UNPACK;
      S_UNPACK:  begin pcpi_wait = 1'b1; state_next = S_SPECIAL; end
      S_SPECIAL: begin pcpi_wait = 1'b1; state_next = special_hit ? S_DONE : S_ALIGN; end
      S_ALIGN: begin
        pcpi_wait = 1'b1;
        if ((exp_diff > 10'sd26) || (exp_diff <= 10'sd1)) state_next = S_ADD;
      end
      S_ADD:  begin pcpi_wait = 1'b1; state_next = (sum_comb == 28'd0) ? S_DONE : S_NORM; end
      S_NORM: begin
        pcpi_wait = 1'b1;
        if (sum_reg[27] || !(norm_left || norm_right)) state_next = S_ROUND;
      end
      S_ROUND: begin pcpi_wait = 1'b1; state_next = S_PACK; end
      S_PACK:  begin pcpi_wait = 1'b1; state_next = S_DONE; end
      S_DONE: begin
        pcpi_wr = 1'b1; pcpi_ready = 1'b1; pcpi_rd = result_reg; state_next = S_COOL;
      end
      S_COOL:  begin pcpi_rd = result_reg; state_next = S_IDLE; end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_reg <= 32'd0; b_reg <= 32'd0; result_reg <= 32'd0;
      sub_reg <= 1'b0; rm_reg <= 3'd0;
      sign_a_reg <= 1'b0; sign_b_reg <= 1'b0; sign_r_reg <= 1'b0;
      exp_a_reg <= 10'sd0; exp_b_reg <= 10'sd0; exp_r_reg <= 10'sd0;
      man_a_reg <= 27'd0; man_b_reg <= 27'd0; sum_reg <= 28'd0; mant_reg <= 24'd0;
    end else begin
      case (state_reg)
        S_IDLE: if (match) begin
          a_reg <= pcpi_rs1; b_reg <= pcpi_rs2;
          sub_reg <= (pcpi_insn[31:25] == FUNCT7_SUB); rm_reg <= rm_dec;
        end
        S_UNPACK: begin
          sign_a_reg <= a_reg[31];
          sign_b_reg <= b_reg[31] ^ sub_reg;
          exp_a_reg  <= (a_reg[30:23] == 8'd0) ? -10'sd126 : $signed({2'b00, a_reg[30:23]}) - 10'sd127;
          exp_b_reg  <= (b_reg[30:23] == 8'd0) ? -10'sd126 : $signed({2'b00, b_reg[30:23]}) - 10'sd127;
          man_a_reg  <= {(a_reg[30:23] != 8'd0), a_reg[22:0], 3'b000};
          man_b_reg  <= {(b_reg[30:23] != 8'd0), b_reg[22:0], 3'b000};
        end
        S_SPECIAL: begin
          if (a_nan || b_nan || inf_invalid) result_reg <= 32'h7FC00000;
          else if (a_inf)                    result_reg <= {sign_a_reg, 8'hFF, 23'd0};
          else if (b_inf)                    result_reg <= {sign_b_reg, 8'hFF, 23'd0};
          else if (a_zero && b_zero)         result_reg <= {zero_sign, 31'd0};
          else if (exp_b_reg > exp_a_reg) begin
            // Keep the larger exponent in the a slot so only b ever shifts.
            sign_a_reg <= sign_b_reg; sign_b_reg <= sign_a_reg;
            exp_a_reg  <= exp_b_reg;  exp_b_reg  <= exp_a_reg;
            man_a_reg  <= man_b_reg;  man_b_reg  <= man_a_reg;
          end
        end
        S_ALIGN: begin
          if (exp_diff > 10'sd26) begin
            man_b_reg <= {26'd0, |man_b_reg};
            exp_b_reg <= exp_a_reg;
          end else if (exp_diff != 10'sd0) begin
            man_b_reg <= {1'b0, man_b_reg[26:2], man_b_reg[1] | man_b_reg[0]};
            exp_b_reg <= exp_b_reg + 10'sd1;
          end
        end
        S_ADD: begin
          sum_reg    <= sum_comb;
          sign_r_reg <= (eff_sub && !a_ge) ? sign_b_reg : sign_a_reg;
          exp_r_reg  <= exp_a_reg;
          if (sum_comb == 28'd0) result_reg <= {zero_sign, 31'd0};
        end
        S_NORM: begin
          if (sum_reg[27] || norm_right) begin
            sum_reg   <= {1'b0, sum_reg[27:2], sum_reg[1] | sum_reg[0]};
            exp_r_reg <= exp_r_reg + 10'sd1;
          end else if (norm_left) begin
            sum_reg   <= {sum_reg[26:0], 1'b0};
            exp_r_reg <= exp_r_reg - 10'sd1;
          end
        end
        S_ROUND: begin
          if (mant_sum[24]) begin
            mant_reg  <= mant_sum[24:1];
            exp_r_reg <= exp_r_reg + 10'sd1;
          end else begin
            mant_reg  <= mant_sum[23:0];
          end
        end
        S_PACK: begin
          if (overflow)
            result_reg <= ovf_inf ? {sign_r_reg, 8'hFF, 23'd0} : {sign_r_reg, 8'hFE, 23'h7FFFFF};
          else if (mant_reg[23]) result_reg <= {sign_r_reg, exp_field, mant_reg[22:0]};
          else                   result_reg <= {sign_r_reg, 8'd0, mant_reg[22:0]};
        end
        default: ;
      endcase
    end
  end

`ifdef FPADDSUB_FLAGS_EN
  logic [4:0] op_flags_reg, fflags_reg;
  logic       nv_hit;
  assign nv_hit = (a_nan && !a_reg[22]) || (b_nan && !b_reg[22]) || inf_invalid;

  // {NV,DZ,OF,UF,NX}; DZ cannot occur in add/sub.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_flags_reg <= 5'd0;
      fflags_reg   <= 5'd0;
    end else begin
      case (state_reg)
        S_IDLE:    if (match) op_flags_reg <= 5'd0;
        S_SPECIAL: if (special_hit) op_flags_reg <= {nv_hit, 4'b0000};
        S_ROUND:   op_flags_reg <= {4'b0000, inexact};
        S_PACK:    op_flags_reg <= {2'b00, overflow, !mant_reg[23] && op_flags_reg[0],
                                    op_flags_reg[0] || overflow};
        default: ;
      endcase
      if (fflags_clr)               fflags_reg <= 5'd0;
      else if (state_reg == S_DONE) fflags_reg <= fflags_reg | op_flags_reg;
    end
  end
  assign fflags = fflags_reg;
`endif

endmodule

// File: tb/tb_picorv32_pcpi_fpaddsub.sv
// Scoreboard bench for picorv32_pcpi_fpaddsub: stimulus queues expected results, a monitor checks strobes.
module tb_picorv32_pcpi_fpaddsub;
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0000100;
  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;
  localparam logic [4:0] FL_NV = 5'b10000, FL_OF = 5'b00100, FL_NX = 5'b00001;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = 32'd0;
  logic [31:0] pcpi_rs1 = 32'd0;
  logic [31:0] pcpi_rs2 = 32'd0;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
`ifdef FPADDSUB_FLAGS_EN
  logic [4:0]  fflags;
  logic        fflags_clr = 1'b0;
`endif

  picorv32_pcpi_fpaddsub dut (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
`ifdef FPADDSUB_FLAGS_EN
    , .fflags(fflags), .fflags_clr(fflags_clr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic [4:0]  fl;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [4:0] exp_flags = 5'd0;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0001011};
  endfunction

  initial begin : monitor
    logic prev_strobe;
    exp_t e;
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn && (pcpi_ready || pcpi_wr)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: wr=%0b ready=%0b rd=%08h, required no strobe",
                   pcpi_wr, pcpi_ready, pcpi_rd);
        end else begin
          e = exp_q.pop_front();
          if (!(pcpi_ready && pcpi_wr && !prev_strobe && pcpi_rd === e.rd)) begin
            errors++;
            $display("FAIL %s: rd=%08h wr=%0b ready=%0b repeated=%0b, required rd=%08h wr=1 ready=1 single pulse",
                     e.name, pcpi_rd, pcpi_wr, pcpi_ready, prev_strobe, e.rd);
          end else begin
            $display("ok   %s: rd=%08h (flags expected %05b)", e.name, pcpi_rd, e.fl);
          end
        end
      end
      prev_strobe = resetn && (pcpi_ready || pcpi_wr);
    end
  end

  task automatic check_idle(input string name);
    logic bad;
    bad = (pcpi_wr !== 1'b0) || (pcpi_ready !== 1'b0) || (pcpi_wait !== 1'b0) || (pcpi_rd !== 32'd0);
`ifdef FPADDSUB_FLAGS_EN
    bad = bad || (fflags !== 5'd0);
`endif
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: wr=%0b ready=%0b wait=%0b rd=%08h, required all zero", name, pcpi_wr, pcpi_ready, pcpi_wait, pcpi_rd);
    end
  endtask

  task automatic run_op(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] rd, input logic [4:0] fl,
                        input string name);
    int   cyc;
    logic got, wait_ok;
    exp_q.push_back('{rd: rd, fl: fl, name: name});
    pcpi_insn = mk(f7, f3); pcpi_rs1 = a; pcpi_rs2 = b; pcpi_valid = 1'b1;
    cyc = 0; got = 1'b0; wait_ok = 1'b1;
    while (!got && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (pcpi_ready) got = 1'b1;
      else if (!pcpi_wait) wait_ok = 1'b0;
    end
    pcpi_valid = 1'b0;
    checks++;
    if (!got || !wait_ok || pcpi_wait || cyc > 37) begin
      errors++;
      $display("FAIL %s_handshake: ready_seen=%0b wait_held=%0b wait_at_done=%0b cycles=%0d, required 1 1 0 and <=37",
               name, got, wait_ok, pcpi_wait, cyc);
    end
    repeat (2) @(posedge clk);
    #1;
`ifdef FPADDSUB_FLAGS_EN
    exp_flags = exp_flags | fl;
    checks++;
    if (fflags !== exp_flags) begin
      errors++;
      $display("FAIL %s_flags: fflags=%05b, required %05b", name, fflags, exp_flags);
    end
`endif
  endtask

`ifdef FPADDSUB_FLAGS_EN
  task automatic clear_flags();
    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    exp_flags = 5'd0;
    checks++;
    if (fflags !== 5'd0) begin
      errors++;
      $display("FAIL flags_clear: fflags=%05b, required 00000", fflags);
    end
  endtask
`endif

  task automatic ignore_test(input logic [31:0] insn, input string name);
    logic bad;
    bad = 1'b0;
    pcpi_insn = insn; pcpi_rs1 = 32'h3F800000; pcpi_rs2 = 32'h3F800000; pcpi_valid = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (pcpi_wr || pcpi_ready || pcpi_wait || (pcpi_rd != 32'd0)) bad = 1'b1;
    end
    pcpi_valid = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: DUT responded to a foreign insn, required outputs to stay 0", name);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_state");
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op(F7_ADD, RNE, 32'h3F800000, 32'h40000000, 32'h40400000, 5'd0, "fadd_1p2");
    run_op(F7_SUB, RNE, 32'h3F800000, 32'h3F800000, 32'h00000000, 5'd0, "fsub_zero_rne");
    run_op(F7_SUB, RDN, 32'h3F800000, 32'h3F800000, 32'h80000000, 5'd0, "fsub_zero_rdn");
    run_op(F7_ADD, RNE, 32'h3F800000, 32'h33800000, 32'h3F800000, FL_NX, "tie_rne");
    run_op(F7_ADD, RUP, 32'h3F800000, 32'h33800000, 32'h3F800001, FL_NX, "tie_rup");
    run_op(F7_ADD, RMM, 32'h3F800000, 32'h33800000, 32'h3F800001, FL_NX, "tie_rmm");
    run_op(F7_ADD, 3'd7, 32'h3F800000, 32'h33800000, 32'h3F800000, FL_NX, "tie_dyn");
    run_op(F7_ADD, 3'd5, 32'h3F800000, 32'h33800000, 32'h3F800000, FL_NX, "tie_reserved_rm");
    run_op(F7_ADD, RNE, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, FL_OF | FL_NX, "ovf_rne");
    run_op(F7_ADD, RTZ, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, FL_OF | FL_NX, "ovf_rtz");
    run_op(F7_ADD, RDN, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, FL_OF | FL_NX, "ovf_rdn_neg");
    run_op(F7_ADD, RNE, 32'h7F800000, 32'hFF800000, 32'h7FC00000, FL_NV, "inf_minus_inf");
`ifdef FPADDSUB_FLAGS_EN
    clear_flags();
`endif
    run_op(F7_ADD, RNE, 32'h7F800001, 32'h3F800000, 32'h7FC00000, FL_NV, "snan_in");
    run_op(F7_ADD, RNE, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'd0, "qnan_in");
    run_op(F7_ADD, RNE, 32'h7F800000, 32'h3F800000, 32'h7F800000, 5'd0, "inf_plus_one");
    run_op(F7_SUB, RNE, 32'h7F800000, 32'h7F800000, 32'h7FC00000, FL_NV, "fsub_inf_inf");
    run_op(F7_SUB, RNE, 32'h3F800001, 32'h3F800000, 32'h34000000, 5'd0, "cancel_norm");
    run_op(F7_SUB, RNE, 32'h40000000, 32'h3F800000, 32'h3F800000, 5'd0, "fsub_2m1");
    run_op(F7_SUB, RNE, 32'h3F800000, 32'h40000000, 32'hBF800000, 5'd0, "fsub_1m2");
    run_op(F7_ADD, RNE, 32'h80000000, 32'h80000000, 32'h80000000, 5'd0, "negzero_sum");
    run_op(F7_ADD, RUP, 32'h3F800000, 32'h00000001, 32'h3F800001, FL_NX, "far_sticky_rup");

    ignore_test({7'b0000001, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0001011}, "ignore_funct7");
    ignore_test({7'b0000000, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011}, "ignore_opcode");

    // Abort mid-alignment: the dropped op must never strobe.
    pcpi_insn = mk(F7_ADD, RNE); pcpi_rs1 = 32'h3F800000; pcpi_rs2 = 32'h33800000; pcpi_valid = 1'b1;
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (pcpi_wait !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_align: wait=%0b, required 1", pcpi_wait);
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    exp_flags = 5'd0;
    check_idle("reset_abort");
    resetn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_idle("after_abort");

    run_op(F7_ADD, RNE, 32'h00000001, 32'h00000001, 32'h00000002, 5'd0, "denorm_add");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
